// File: rtl/vending_transaction_controller.sv
// Vending transaction controller: credits coins, dispenses affordable items,
// and pays the balance back through a coin hopper after a timeout or a user
// request. Balance, wait timer, presented return coin and FSM state are all
// registered; availability and the gated hopper outputs are derived
// combinationally from those registers.
module vending_transaction_controller #(
    parameter int kNumCoins   = 3,
    parameter int kNumItems   = 4,
    parameter int kTotalBits  = 31,
    parameter int kWaitTime   = 10,
    parameter int kMaxBalance = 10000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [kNumCoins-1:0]  i_input_coin,
    input  logic [kNumItems-1:0]  i_select_item,
    input  logic                  i_trigger_return,
    input  logic                  i_hopper_ready,
    output logic [kNumItems-1:0]  o_available_item,
    output logic [kNumItems-1:0]  o_output_item,
    output logic [kNumCoins-1:0]  o_return_coin,
    output logic                  o_coin_reject,
    output logic [kTotalBits-1:0] o_current_total,
    output logic                  o_busy
);

    localparam int kTimerBits = (kWaitTime < 2) ? 1 : $clog2(kWaitTime + 1);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        RETURN
    } state_e;

    // Face value of coin type idx; the table is ascending in idx.
    function automatic logic [kTotalBits-1:0] coinValue(input int idx);
        logic [kTotalBits-1:0] value;
        case (idx)
            0:       value = kTotalBits'(100);
            1:       value = kTotalBits'(500);
            default: value = kTotalBits'(1000);
        endcase
        return value;
    endfunction

    // Price of item type idx.
    function automatic logic [kTotalBits-1:0] itemPrice(input int idx);
        logic [kTotalBits-1:0] value;
        case (idx)
            0:       value = kTotalBits'(400);
            1:       value = kTotalBits'(500);
            2:       value = kTotalBits'(1000);
            default: value = kTotalBits'(2000);
        endcase
        return value;
    endfunction

    // Value of a coin strobe; only meaningful when the strobe is one-hot.
    function automatic logic [kTotalBits-1:0] coinSum(input logic [kNumCoins-1:0] bits);
        logic [kTotalBits-1:0] value;
        value = '0;
        for (int i = 0; i < kNumCoins; i++) begin
            if (bits[i]) begin
                value = value | coinValue(i);
            end
        end
        return value;
    endfunction

    // Price of a select strobe; only meaningful when the strobe is one-hot.
    function automatic logic [kTotalBits-1:0] priceSum(input logic [kNumItems-1:0] bits);
        logic [kTotalBits-1:0] value;
        value = '0;
        for (int i = 0; i < kNumItems; i++) begin
            if (bits[i]) begin
                value = value | itemPrice(i);
            end
        end
        return value;
    endfunction

    // Largest coin not exceeding bal; the ascending table lets the last hit win.
    function automatic logic [kNumCoins-1:0] largestCoin(input logic [kTotalBits-1:0] bal);
        logic [kNumCoins-1:0] pick;
        pick = '0;
        for (int i = 0; i < kNumCoins; i++) begin
            if (coinValue(i) <= bal) begin
                pick = kNumCoins'(1) << i;
            end
        end
        return pick;
    endfunction

    state_e                state_q, state_d;
    logic [kTotalBits-1:0] balance_q, balance_d;
    logic [kTimerBits-1:0] timer_q, timer_d;
    logic [kNumCoins-1:0]  returnCoin_q, returnCoin_d;
    logic [kNumItems-1:0]  outputItem_q, outputItem_d;
    logic                  coinReject_q, coinReject_d;

    logic [kTotalBits-1:0] coinAmount;
    logic [kTotalBits-1:0] creditAmount;
    logic [kTotalBits-1:0] selectPrice;
    logic [kTotalBits-1:0] chargeAmount;
    logic [kTotalBits-1:0] hopperAmount;
    logic                  coinInserted;
    logic                  coinCredit;
    logic                  selectValid;
    logic                  timerReload;

    // Qualify this cycle's coin, select and hopper hand-off against the pre-cycle balance.
    always_comb begin
        coinAmount   = coinSum(i_input_coin);
        coinInserted = |i_input_coin;
        coinCredit   = $onehot(i_input_coin)
                       && ((balance_q + coinAmount) <= kTotalBits'(kMaxBalance));
        creditAmount = coinCredit ? coinAmount : '0;
        selectPrice  = priceSum(i_select_item);
        selectValid  = (state_q == ACTIVE) && $onehot(i_select_item)
                       && !i_trigger_return && (selectPrice <= balance_q);
        chargeAmount = selectValid ? selectPrice : '0;
        hopperAmount = ((state_q == RETURN) && i_hopper_ready) ? coinSum(returnCoin_q) : '0;
    end

    // State register: asynchronous active-low reset abandons any pending balance.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: balance, wait timer, presented coin and one-cycle pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            balance_q    <= '0;
            timer_q      <= '0;
            returnCoin_q <= '0;
            outputItem_q <= '0;
            coinReject_q <= 1'b0;
        end else begin
            balance_q    <= balance_d;
            timer_q      <= timer_d;
            returnCoin_q <= returnCoin_d;
            outputItem_q <= outputItem_d;
            coinReject_q <= coinReject_d;
        end
    end

    // Next-state and next-datapath logic for the IDLE / ACTIVE / RETURN flow.
    always_comb begin
        state_d      = state_q;
        balance_d    = balance_q;
        timer_d      = timer_q;
        returnCoin_d = returnCoin_q;
        outputItem_d = '0;
        coinReject_d = coinInserted && !coinCredit;
        timerReload  = 1'b0;
        case (state_q)
            IDLE: begin
                balance_d    = creditAmount;
                returnCoin_d = '0;
                if (coinCredit) begin
                    state_d = ACTIVE;
                    timer_d = kTimerBits'(kWaitTime);
                end
            end
            ACTIVE: begin
                timerReload  = coinCredit || selectValid;
                balance_d    = balance_q + creditAmount - chargeAmount;
                outputItem_d = selectValid ? i_select_item : '0;
                if (timerReload) begin
                    timer_d = kTimerBits'(kWaitTime);
                end else if (timer_q != '0) begin
                    timer_d = timer_q - kTimerBits'(1);
                end
                if (i_trigger_return || (!timerReload && (timer_q <= kTimerBits'(1)))) begin
                    timer_d = '0;
                    if (balance_d != '0) begin
                        state_d      = RETURN;
                        returnCoin_d = largestCoin(balance_d);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            RETURN: begin
                balance_d = balance_q + creditAmount - hopperAmount;
                if (i_hopper_ready) begin
                    if (balance_d == '0) begin
                        state_d      = IDLE;
                        returnCoin_d = '0;
                    end else begin
                        returnCoin_d = largestCoin(balance_d);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode: availability only while shopping, hopper coin only while returning.
    always_comb begin
        o_available_item = '0;
        if (state_q == ACTIVE) begin
            for (int i = 0; i < kNumItems; i++) begin
                o_available_item[i] = (balance_q >= itemPrice(i));
            end
        end
        o_return_coin   = (state_q == RETURN) ? returnCoin_q : '0;
        o_busy          = (state_q == RETURN);
        o_output_item   = outputItem_q;
        o_coin_reject   = coinReject_q;
        o_current_total = balance_q;
    end

endmodule

// File: tb/tb_vending_transaction_controller.sv
// Bench for vending_transaction_controller: directed transactions; dispense,
// reject and hopper-acceptance events are expected through a queue and matched
// by an independent monitor, while balance/state levels are checked directly.
module tb_vending_transaction_controller;

    localparam int kDispense = 0;
    localparam int kReject   = 1;
    localparam int kHopper   = 2;

    logic        clk;
    logic        reset_n;
    logic [2:0]  i_input_coin;
    logic [3:0]  i_select_item;
    logic        i_trigger_return;
    logic        i_hopper_ready;
    logic [3:0]  o_available_item;
    logic [3:0]  o_output_item;
    logic [2:0]  o_return_coin;
    logic        o_coin_reject;
    logic [30:0] o_current_total;
    logic        o_busy;

    typedef struct {
        int          kind;
        logic [31:0] value;
        string       name;
    } expect_t;

    expect_t sbQ[$];
    int      vectors     = 0;
    int      miscompares = 0;

    vending_transaction_controller dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .i_input_coin     (i_input_coin),
        .i_select_item    (i_select_item),
        .i_trigger_return (i_trigger_return),
        .i_hopper_ready   (i_hopper_ready),
        .o_available_item (o_available_item),
        .o_output_item    (o_output_item),
        .o_return_coin    (o_return_coin),
        .o_coin_reject    (o_coin_reject),
        .o_current_total  (o_current_total),
        .o_busy           (o_busy)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, actual, expected);
        end
    endtask

    task automatic checkLevels(input string name, input int total, input logic [3:0] avail,
                               input logic busy, input logic [2:0] coin);
        checkOutput({name, ".total"}, 32'(o_current_total), 32'(total));
        checkOutput({name, ".available"}, 32'(o_available_item), 32'(avail));
        checkOutput({name, ".busy"}, 32'(o_busy), 32'(busy));
        checkOutput({name, ".return_coin"}, 32'(o_return_coin), 32'(coin));
    endtask

    task automatic pushExpect(input int kind, input logic [31:0] value, input string name);
        expect_t e;
        e.kind  = kind;
        e.value = value;
        e.name  = name;
        sbQ.push_back(e);
    endtask

    // Drive one cycle of inputs, let the DUT sample them, return #1 after the edge.
    task automatic applyStimulus(input logic [2:0] coin, input logic [3:0] sel,
                                 input logic trig, input logic hopper);
        i_input_coin     = coin;
        i_select_item    = sel;
        i_trigger_return = trig;
        i_hopper_ready   = hopper;
        @(posedge clk);
        #1;
        i_input_coin     = '0;
        i_select_item    = '0;
        i_trigger_return = 1'b0;
    endtask

    task automatic idleCycles(input int n, input logic hopper);
        for (int k = 0; k < n; k++) begin
            applyStimulus(3'b000, 4'b0000, 1'b0, hopper);
        end
    endtask

    task automatic scoreEvent(input int kind, input logic [31:0] value, input string tag);
        expect_t e;
        vectors++;
        if (sbQ.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL unexpected_%s: got 'h%0h, expected no event", tag, value);
        end else begin
            e = sbQ.pop_front();
            if ((e.kind != kind) || (e.value !== value)) begin
                miscompares++;
                $display("[TB] FAIL %s: got %s 'h%0h, expected kind %0d 'h%0h",
                         e.name, tag, value, e.kind, e.value);
            end
        end
    endtask

    // Monitor: mid-cycle sampling of pulses and hopper hand-offs.
    initial begin
        forever begin
            @(negedge clk);
            if (o_output_item != 4'b0000) begin
                scoreEvent(kDispense, 32'(o_output_item), "dispense");
            end
            if (o_coin_reject) begin
                scoreEvent(kReject, 32'd1, "reject");
            end
            if ((o_return_coin != 3'b000) && i_hopper_ready) begin
                scoreEvent(kHopper, 32'(o_return_coin), "hopper");
            end
        end
    end

    initial begin
        reset_n          = 1'b1;
        i_input_coin     = '0;
        i_select_item    = '0;
        i_trigger_return = 1'b0;
        i_hopper_ready   = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        checkLevels("reset", 0, 4'b0000, 1'b0, 3'b000);
        checkOutput("reset.output_item", 32'(o_output_item), 32'd0);
        checkOutput("reset.coin_reject", 32'(o_coin_reject), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Insert 1000, buy item 0, then return with a same-cycle select that must lose.
        applyStimulus(3'b100, 4'b0000, 1'b0, 1'b0);
        checkLevels("A.credit1000", 1000, 4'b0111, 1'b0, 3'b000);
        pushExpect(kDispense, 32'h1, "A.dispense0");
        applyStimulus(3'b000, 4'b0001, 1'b0, 1'b0);
        checkLevels("A.after_select", 600, 4'b0011, 1'b0, 3'b000);
        checkOutput("A.pulse", 32'(o_output_item), 32'h1);
        pushExpect(kHopper, 32'b010, "A.return500");
        pushExpect(kHopper, 32'b001, "A.return100");
        applyStimulus(3'b000, 4'b0001, 1'b1, 1'b1);
        checkLevels("A.return_entry", 600, 4'b0000, 1'b1, 3'b010);
        idleCycles(2, 1'b1);
        checkLevels("A.idle", 0, 4'b0000, 1'b0, 3'b000);

        // Insert 500 and wait out the timer.
        applyStimulus(3'b010, 4'b0000, 1'b0, 1'b0);
        checkLevels("B.credit500", 500, 4'b0011, 1'b0, 3'b000);
        idleCycles(9, 1'b0);
        checkLevels("B.timer_one_left", 500, 4'b0011, 1'b0, 3'b000);
        idleCycles(1, 1'b0);
        checkLevels("B.timeout_return", 500, 4'b0000, 1'b1, 3'b010);
        pushExpect(kHopper, 32'b010, "B.return500");
        applyStimulus(3'b000, 4'b0000, 1'b0, 1'b1);
        checkLevels("B.idle", 0, 4'b0000, 1'b0, 3'b000);

        // Balance 1700 drained with the hopper always ready.
        applyStimulus(3'b100, 4'b0000, 1'b0, 1'b0);
        applyStimulus(3'b010, 4'b0000, 1'b0, 1'b0);
        applyStimulus(3'b001, 4'b0000, 1'b0, 1'b0);
        applyStimulus(3'b001, 4'b0000, 1'b0, 1'b0);
        checkLevels("C.balance1700", 1700, 4'b0111, 1'b0, 3'b000);
        pushExpect(kHopper, 32'b100, "C.return1000");
        pushExpect(kHopper, 32'b010, "C.return500");
        pushExpect(kHopper, 32'b001, "C.return100a");
        pushExpect(kHopper, 32'b001, "C.return100b");
        applyStimulus(3'b000, 4'b0000, 1'b1, 1'b1);
        checkLevels("C.return_entry", 1700, 4'b0000, 1'b1, 3'b100);
        idleCycles(3, 1'b1);
        checkLevels("C.last_coin", 100, 4'b0000, 1'b1, 3'b001);
        idleCycles(1, 1'b1);
        checkLevels("C.idle", 0, 4'b0000, 1'b0, 3'b000);

        // Same-cycle coin and select: affordability uses the pre-cycle balance.
        for (int k = 0; k < 4; k++) begin
            applyStimulus(3'b001, 4'b0000, 1'b0, 1'b0);
        end
        checkLevels("D.balance400", 400, 4'b0001, 1'b0, 3'b000);
        applyStimulus(3'b001, 4'b0010, 1'b0, 1'b0);
        checkLevels("D.coin_no_buy", 500, 4'b0011, 1'b0, 3'b000);
        checkOutput("D.no_dispense", 32'(o_output_item), 32'd0);
        pushExpect(kDispense, 32'b0010, "D.dispense1");
        applyStimulus(3'b010, 4'b0010, 1'b0, 1'b0);
        checkLevels("D.coin_and_buy", 500, 4'b0011, 1'b0, 3'b000);
        checkOutput("D.pulse", 32'(o_output_item), 32'b0010);
        pushExpect(kHopper, 32'b010, "D.return500");
        applyStimulus(3'b000, 4'b0000, 1'b1, 1'b1);
        idleCycles(1, 1'b1);
        checkLevels("D.idle", 0, 4'b0000, 1'b0, 3'b000);

        // Rejects: multi-bit coin in IDLE, ceiling overflow, multi-bit select.
        pushExpect(kReject, 32'd1, "E.multicoin_idle");
        applyStimulus(3'b101, 4'b0000, 1'b0, 1'b0);
        checkLevels("E.idle_after_reject", 0, 4'b0000, 1'b0, 3'b000);
        for (int k = 0; k < 9; k++) begin
            applyStimulus(3'b100, 4'b0000, 1'b0, 1'b0);
        end
        applyStimulus(3'b010, 4'b0000, 1'b0, 1'b0);
        checkLevels("E.balance9500", 9500, 4'b1111, 1'b0, 3'b000);
        pushExpect(kReject, 32'd1, "E.over_ceiling");
        applyStimulus(3'b100, 4'b0000, 1'b0, 1'b0);
        checkLevels("E.after_reject", 9500, 4'b1111, 1'b0, 3'b000);
        applyStimulus(3'b000, 4'b0011, 1'b0, 1'b0);
        checkLevels("E.multi_select", 9500, 4'b1111, 1'b0, 3'b000);
        checkOutput("E.no_dispense", 32'(o_output_item), 32'd0);
        pushExpect(kReject, 32'd1, "E.multicoin_active");
        applyStimulus(3'b011, 4'b0000, 1'b0, 1'b0);
        checkLevels("E.after_multicoin", 9500, 4'b1111, 1'b0, 3'b000);
        applyStimulus(3'b010, 4'b0000, 1'b0, 1'b0);
        checkLevels("E.at_ceiling", 10000, 4'b1111, 1'b0, 3'b000);
        pushExpect(kReject, 32'd1, "E.past_ceiling");
        applyStimulus(3'b001, 4'b0000, 1'b0, 1'b0);
        checkLevels("E.still_ceiling", 10000, 4'b1111, 1'b0, 3'b000);
        for (int k = 0; k < 10; k++) begin
            pushExpect(kHopper, 32'b100, "E.return1000");
        end
        applyStimulus(3'b000, 4'b0000, 1'b1, 1'b1);
        checkLevels("E.return_entry", 10000, 4'b0000, 1'b1, 3'b100);
        idleCycles(10, 1'b1);
        checkLevels("E.idle", 0, 4'b0000, 1'b0, 3'b000);

        // Stalled hopper, coin credited during RETURN, then reset abandons the balance.
        applyStimulus(3'b100, 4'b0000, 1'b0, 1'b0);
        applyStimulus(3'b001, 4'b0000, 1'b0, 1'b0);
        checkLevels("F.balance1100", 1100, 4'b0111, 1'b0, 3'b000);
        applyStimulus(3'b000, 4'b0000, 1'b1, 1'b0);
        checkLevels("F.return_entry", 1100, 4'b0000, 1'b1, 3'b100);
        idleCycles(5, 1'b0);
        checkLevels("F.stalled", 1100, 4'b0000, 1'b1, 3'b100);
        applyStimulus(3'b010, 4'b0001, 1'b1, 1'b0);
        checkLevels("F.coin_in_return", 1600, 4'b0000, 1'b1, 3'b100);
        checkOutput("F.no_dispense", 32'(o_output_item), 32'd0);
        reset_n = 1'b0;
        #1;
        checkLevels("F.async_reset", 0, 4'b0000, 1'b0, 3'b000);
        checkOutput("F.reset_output_item", 32'(o_output_item), 32'd0);
        checkOutput("F.reset_coin_reject", 32'(o_coin_reject), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        checkLevels("F.after_release", 0, 4'b0000, 1'b0, 3'b000);
        applyStimulus(3'b001, 4'b0000, 1'b0, 1'b0);
        checkLevels("F.fresh_credit", 100, 4'b0000, 1'b0, 3'b000);

        idleCycles(2, 1'b0);
        checkOutput("scoreboard.drained", 32'(sbQ.size()), 32'd0);
        while (sbQ.size() != 0) begin
            expect_t e;
            e = sbQ.pop_front();
            $display("[TB] pending expectation never seen: %s", e.name);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
